// File: rtl/cache_req_scheduler.sv
// L1 front-end: round-robin request arbiter that sequences tag lookup, line fill and replacement update.
// Latency: accept -> response in 3 cycles on hit, 4 on miss, plus one per lk_ack/fill_ack wait cycle.
// Backpressure: one request in flight; rq_ready only in IDLE; lk/fill held until acked; no response stall.
module cache_req_scheduler #(
    parameter int I_SIZE = 64,
    parameter int D_SIZE = 6,
    parameter int C_SIZE = 14,
    parameter int A_SIZE = 8,
    localparam int WAY_BITS   = $clog2(A_SIZE),
    localparam int INDEX_BITS = C_SIZE - WAY_BITS - D_SIZE,
    localparam int TAG_BITS   = I_SIZE - INDEX_BITS - D_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            rq_valid,
    input  logic [I_SIZE-1:0]     rq_addr0,
    input  logic [I_SIZE-1:0]     rq_addr1,
    output logic [1:0]            rq_ready,
    output logic [1:0]            rsp_valid,
    output logic                  rsp_hit,
    output logic [WAY_BITS-1:0]   rsp_way,
    output logic [D_SIZE-1:0]     rsp_byte_sel,
    output logic                  lk_req,
    output logic [TAG_BITS-1:0]   lk_tag,
    output logic [INDEX_BITS-1:0] lk_index,
    input  logic                  lk_ack,
    input  logic                  lk_hit,
    input  logic [WAY_BITS-1:0]   lk_way,
    output logic                  fill_req,
    input  logic                  fill_ack,
    output logic                  upd_valid,
    output logic [INDEX_BITS-1:0] upd_index,
    output logic [WAY_BITS-1:0]   upd_way,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    typedef enum logic [2:0] {IDLE, LOOKUP, FILL, UPDATE, RESP} state_t;

    state_t                state;
    logic                  run;
    logic                  last_grant;
    logic                  gnt_id;
    logic                  gnt;
    logic                  hit_q;
    logic [WAY_BITS-1:0]   way_q;
    logic [I_SIZE-1:0]     addr_q;

    // When both request, the one not served last wins; otherwise the lone requester wins.
    always_comb begin
        gnt = rq_valid[1];
        if (rq_valid == 2'b11) begin
            gnt = ~last_grant;
        end
    end

    // run keeps rq_ready low while reset is held and for the first cycle after release.
    assign rq_ready  = (run && state == IDLE && rq_valid != 2'b00) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign lk_tag    = addr_q[I_SIZE-1 -: TAG_BITS];
    assign lk_index  = addr_q[D_SIZE +: INDEX_BITS];
    assign upd_index = addr_q[D_SIZE +: INDEX_BITS];
    assign upd_way   = way_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            run          <= 1'b0;
            last_grant   <= 1'b1;
            gnt_id       <= 1'b0;
            hit_q        <= 1'b0;
            way_q        <= '0;
            addr_q       <= '0;
            lk_req       <= 1'b0;
            fill_req     <= 1'b0;
            upd_valid    <= 1'b0;
            rsp_valid    <= 2'b00;
            rsp_hit      <= 1'b0;
            rsp_way      <= '0;
            rsp_byte_sel <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
        end else begin
            run <= 1'b1;
            case (state)
                IDLE: begin
                    if (rq_ready != 2'b00) begin
                        gnt_id     <= gnt;
                        last_grant <= gnt;
                        addr_q     <= gnt ? rq_addr1 : rq_addr0;
                        lk_req     <= 1'b1;
                        state      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lk_ack) begin
                        hit_q  <= lk_hit;
                        way_q  <= lk_way;
                        lk_req <= 1'b0;
                        if (lk_hit) begin
                            if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
                            upd_valid <= 1'b1;
                            state     <= UPDATE;
                        end else begin
                            if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
                            fill_req <= 1'b1;
                            state    <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (fill_ack) begin
                        fill_req  <= 1'b0;
                        upd_valid <= 1'b1;
                        state     <= UPDATE;
                    end
                end
                UPDATE: begin
                    upd_valid    <= 1'b0;
                    rsp_valid    <= gnt_id ? 2'b10 : 2'b01;
                    rsp_hit      <= hit_q;
                    rsp_way      <= way_q;
                    rsp_byte_sel <= addr_q[D_SIZE-1:0];
                    state        <= RESP;
                end
                RESP: begin
                    rsp_valid    <= 2'b00;
                    rsp_hit      <= 1'b0;
                    rsp_way      <= '0;
                    rsp_byte_sel <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
